// File: rtl/cntr_down_pkg.sv
// rtl/cntr_down_pkg.sv - shared types and defaults for the loadable down-counter
package cntr_down_pkg;

    localparam int CNTR_WIDTH_DEF        = 4;
    localparam int CNTR_DEFAULT_LOAD_DEF = 2;
    // Register fields are sized for the widest supported counter; upper bits stay zero.
    localparam int CNTR_MAX_WIDTH        = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cntr_state_t;

    typedef struct packed {
        logic [CNTR_MAX_WIDTH-1:0] count;
        logic [CNTR_MAX_WIDTH-1:0] shadow;
        logic                      udf;
    } cntr_regs_t;

endpackage

// File: rtl/cntr_down_zero_det.sv
// rtl/cntr_down_zero_det.sv - combinational count==1 / count==0 detect
module cntr_down_zero_det #(
    parameter int W = 32
) (
    input  logic [W-1:0] count,
    output logic         is_one,
    output logic         is_zero
);

    assign is_one  = (count == W'(1));
    assign is_zero = (count == '0);

endmodule

// File: rtl/cntr_down_udf_ld.sv
// rtl/cntr_down_udf_ld.sv - loadable down-counter with underflow pulse; CNTR_AUTORELOAD_EN enables auto-reload
module cntr_down_udf_ld
    import cntr_down_pkg::*;
#(
    parameter int WIDTH        = CNTR_WIDTH_DEF,
    parameter int DEFAULT_LOAD = CNTR_DEFAULT_LOAD_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enb,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_count,
    output logic             o_udf,
    output logic             o_busy
);

    localparam logic [CNTR_MAX_WIDTH-1:0] DEF_LOAD_W = CNTR_MAX_WIDTH'(DEFAULT_LOAD);

    cntr_state_t state_q, state_d;
    cntr_regs_t  regs_q, regs_d;

    logic [CNTR_MAX_WIDTH-1:0] load_wide;
    logic                      cnt_is_one;
    logic                      cnt_is_zero;

    assign load_wide = CNTR_MAX_WIDTH'(i_load_val);

    cntr_down_zero_det #(
        .W (CNTR_MAX_WIDTH)
    ) u_zero_det (
        .count   (regs_q.count),
        .is_one  (cnt_is_one),
        .is_zero (cnt_is_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            regs_q.count  <= '0;
            regs_q.shadow <= DEF_LOAD_W;
            regs_q.udf    <= 1'b0;
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        regs_d     = regs_q;
        regs_d.udf = 1'b0;

        if (i_clr) begin
            state_d       = ST_IDLE;
            regs_d.count  = '0;
            regs_d.shadow = DEF_LOAD_W;
        end else if (i_load) begin
            // A load always overrides a coincident underflow, so no pulse leaks through.
            regs_d.count  = load_wide;
            regs_d.shadow = load_wide;
            if (load_wide == '0) begin
                state_d    = ST_DONE;
                regs_d.udf = 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end else if (state_q == ST_RUN && i_enb) begin
            if (cnt_is_one) begin
                regs_d.udf = 1'b1;
`ifdef CNTR_AUTORELOAD_EN
                regs_d.count = regs_q.shadow;
                state_d      = ST_RUN;
`else
                regs_d.count = '0;
                state_d      = ST_DONE;
`endif
            end else if (cnt_is_zero) begin
                // Unreachable in normal operation; never let the count wrap.
                state_d = ST_DONE;
            end else begin
                regs_d.count = regs_q.count - CNTR_MAX_WIDTH'(1);
            end
        end
    end

`ifndef CNTR_AUTORELOAD_EN
    logic unused_shadow;
    assign unused_shadow = ^regs_q.shadow;
`endif

    assign o_count = regs_q.count[WIDTH-1:0];
    assign o_udf   = regs_q.udf;
    assign o_busy  = (state_q == ST_RUN);

endmodule

// File: tb/tb_cntr_down_udf_ld.sv
// tb/tb_cntr_down_udf_ld.sv - self-checking bench for cntr_down_udf_ld
module tb_cntr_down_udf_ld;

    localparam int W  = 4;
    localparam int DL = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         enb;
    logic         clr;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         udf;
    logic         busy;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: mode 0 = idle, 1 = running, 2 = done
    int m_count;
    int m_shadow;
    int m_mode;
    bit m_udf;

    cntr_down_udf_ld #(
        .WIDTH        (W),
        .DEFAULT_LOAD (DL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_enb      (enb),
        .i_clr      (clr),
        .i_load     (load),
        .i_load_val (load_val),
        .o_count    (count),
        .o_udf      (udf),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_count  = 0;
        m_shadow = DL;
        m_mode   = 0;
        m_udf    = 0;
    endtask

    task automatic model_step();
        bit next_udf;
        next_udf = 0;
        if (clr) begin
            m_count  = 0;
            m_shadow = DL;
            m_mode   = 0;
        end else if (load) begin
            m_count  = int'(load_val);
            m_shadow = int'(load_val);
            m_mode   = (load_val == 0) ? 2 : 1;
            next_udf = (load_val == 0);
        end else if (m_mode == 1 && enb) begin
            if (m_count == 1) begin
                next_udf = 1;
`ifdef CNTR_AUTORELOAD_EN
                m_count = m_shadow;
`else
                m_count = 0;
                m_mode  = 2;
`endif
            end else begin
                m_count = m_count - 1;
            end
        end
        m_udf = next_udf;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enb = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
        model_reset();
        #2;
        n_cmp++;
        if (count !== 4'd0 || busy !== 1'b0 || udf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_initial: count=%0d busy=%b udf=%b, want 0/0/0", count, busy, udf);
        end
        tick();
        rst = 1'b0;
        load = 1'b1; load_val = 4'd8; enb = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (count !== 4'd5 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_setup: count=%0d busy=%b, want 5/1", count, busy);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (count !== 4'd0 || busy !== 1'b0 || udf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: count=%0d busy=%b udf=%b, want 0/0/0", count, busy, udf);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (udf !== 1'b0 || count !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_hold: count=%0d udf=%b, want 0/0", count, udf);
            end
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (count !== 4'd0 || busy !== 1'b0 || udf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_resume: count=%0d busy=%b udf=%b, want 0/0/0", count, busy, udf);
        end
    endtask

    task automatic test_countdown();
        int exp_c;
        bit exp_u;
        bit exp_b;
        load = 1'b1; load_val = 4'd3; enb = 1'b1;
        tick();
        load = 1'b0;
        n_cmp++;
        if (count !== 4'd3 || busy !== 1'b1 || udf !== 1'b0) begin
            n_fail++;
            $display("FAIL countdown_load: count=%0d busy=%b udf=%b, want 3/1/0", count, busy, udf);
        end
        for (int k = 1; k <= 9; k++) begin
            tick();
`ifdef CNTR_AUTORELOAD_EN
            exp_c = 3 - (k % 3);
            exp_u = (k % 3 == 0);
            exp_b = 1;
`else
            exp_c = (k < 3) ? 3 - k : 0;
            exp_u = (k == 3);
            exp_b = (k < 3);
`endif
            n_cmp++;
            if (count !== 4'(exp_c) || udf !== exp_u || busy !== exp_b) begin
                n_fail++;
                $display("FAIL countdown_k%0d: count=%0d udf=%b busy=%b, want %0d/%b/%b",
                         k, count, udf, busy, exp_c, exp_u, exp_b);
            end
        end
        enb = 1'b0;
    endtask

    task automatic test_load_zero();
        load = 1'b1; load_val = 4'd0; enb = 1'b1;
        tick();
        load = 1'b0;
        n_cmp++;
        if (count !== 4'd0 || udf !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_zero: count=%0d udf=%b busy=%b, want 0/1/0", count, udf, busy);
        end
        tick();
        n_cmp++;
        if (count !== 4'd0 || udf !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_zero_after: count=%0d udf=%b busy=%b, want 0/0/0", count, udf, busy);
        end
        enb = 1'b0;
    endtask

    task automatic test_load_wins();
        load = 1'b1; load_val = 4'd4; enb = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (count !== 4'd1) begin
            n_fail++;
            $display("FAIL load_wins_setup: count=%0d, want 1", count);
        end
        load = 1'b1; load_val = 4'd7;
        tick();
        load = 1'b0;
        n_cmp++;
        if (count !== 4'd7 || udf !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL load_wins: count=%0d udf=%b busy=%b, want 7/0/1", count, udf, busy);
        end
        tick();
        n_cmp++;
        if (count !== 4'd6 || udf !== 1'b0) begin
            n_fail++;
            $display("FAIL load_wins_next: count=%0d udf=%b, want 6/0", count, udf);
        end
        enb = 1'b0;
    endtask

    task automatic test_clr_load();
        clr = 1'b1; load = 1'b1; load_val = 4'd9; enb = 1'b0;
        tick();
        clr = 1'b0; load = 1'b0;
        n_cmp++;
        if (count !== 4'd0 || busy !== 1'b0 || udf !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_over_load: count=%0d busy=%b udf=%b, want 0/0/0", count, busy, udf);
        end
        enb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (count !== 4'd0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_ignores_enb_%0d: count=%0d busy=%b, want 0/0", i, count, busy);
            end
        end
        enb = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clr      = ($urandom_range(0, 15) == 0);
            load     = ($urandom_range(0, 7) == 0);
            load_val = W'($urandom_range(0, 15));
            enb      = ($urandom_range(0, 3) != 0);
            tick();
            n_cmp++;
            if (count !== W'(m_count) || udf !== m_udf || busy !== (m_mode == 1)) begin
                n_fail++;
                $display("FAIL random_%0d: count=%0d udf=%b busy=%b, want %0d/%b/%b",
                         i, count, udf, busy, m_count, m_udf, (m_mode == 1));
            end
        end
        clr = 1'b0; load = 1'b0; enb = 1'b0;
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_load_zero();
        test_load_wins();
        test_clr_load();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cntr_down_udf_ld.md
CNTR_DOWN_UDF_LD -- requirements
Module: cntr_down_udf_ld

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 The block SHALL have parameter DEFAULT_LOAD, default 2, giving the reload value used after clear.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port i_enb, input, 1 bit: count-enable; the counter decrements only when high.
REQ-006 The block SHALL have port i_clr, input, 1 bit: synchronous clear.
REQ-007 The block SHALL have port i_load, input, 1 bit: synchronous load strobe.
REQ-008 The block SHALL have port i_load_val, input, WIDTH bits: value captured on i_load.
REQ-009 The block SHALL have port o_count, output, WIDTH bits: current count.
REQ-010 The block SHALL have port o_udf, output, 1 bit: registered one-cycle underflow pulse.
REQ-011 The block SHALL have port o_busy, output, 1 bit: high while the FSM is in RUN.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE; o_busy SHALL equal (state==RUN).
REQ-013 Per-edge priority SHALL be: i_clr > i_load > i_enb decrement > hold.
REQ-014 i_clr SHALL force count=0, state=IDLE, o_udf=0 and shadow=DEFAULT_LOAD, in any state.
REQ-015 i_load SHALL set count=i_load_val and shadow=i_load_val; the next state SHALL be RUN if i_load_val!=0, otherwise DONE with o_udf=1 for one cycle.
REQ-016 In RUN with i_enb=1 and count>1, count SHALL decrement by 1 with no wrap.
REQ-017 In RUN with i_enb=1 and count==1, count SHALL become 0 and o_udf SHALL be high for exactly the following cycle (the underflow event).
REQ-018 In RUN with i_enb=0, count and state SHALL hold.
REQ-019 In IDLE and DONE, i_enb SHALL be ignored and count SHALL hold.
REQ-020 o_udf SHALL be 0 in every cycle not immediately following an underflow event or a zero load.
REQ-021 Latency: load or clear SHALL be visible on o_count one edge after the strobe; a load of N with i_enb held high SHALL produce o_udf high in the cycle after the Nth subsequent edge.
REQ-022 If i_load coincides with an underflow condition, the load SHALL win and no o_udf pulse SHALL occur.
REQ-023 Arithmetic SHALL be unsigned WIDTH-bit; count SHALL never pass below 0.

Reset
REQ-024 Asserting rst SHALL immediately force state=IDLE, o_count=0, o_udf=0, o_busy=0 and shadow=DEFAULT_LOAD, independent of clk.
REQ-025 Reset asserted mid-count SHALL abort the count with no o_udf pulse, and the block SHALL resume at the first clk edge after deassertion.

Configuration
REQ-026 Macro CNTR_AUTORELOAD_EN SHALL control auto-reload behaviour.
REQ-027 With CNTR_AUTORELOAD_EN defined, an underflow event SHALL load count=shadow and stay in RUN while still pulsing o_udf, and a load of 0 SHALL still go to DONE.
REQ-028 Without CNTR_AUTORELOAD_EN, an underflow event SHALL go to DONE and hold count=0 until i_load or i_clr.

Structure
REQ-029 Package cntr_down_pkg SHALL hold the state enum type, the struct holding count, shadow and udf, and the WIDTH and DEFAULT_LOAD defaults.
REQ-030 Sub-module cntr_down_zero_det (combinational count==1 and count==0 detect) SHALL be the only sub-module.

Verification
REQ-031 The bench SHALL check: rst pulse mid-RUN at count=5 -> o_count=0, o_busy=0, o_udf stays 0, without waiting for clk.
REQ-032 The bench SHALL check: load 3 with i_enb=1 -> o_count 3,2,1,0 on successive cycles, o_udf high for exactly one cycle after reaching 0, final state DONE (macro off).
REQ-033 The bench SHALL check: load 3 with macro on -> o_count sequence 3,2,1,3,2,1,..., o_udf pulsing once every 3 cycles, o_busy constantly high.
REQ-034 The bench SHALL check: load 0 -> o_count=0, o_udf high for one cycle, o_busy=0.
REQ-035 The bench SHALL check: at count=1 with i_enb=1, i_load=1 and i_load_val=7 -> o_count=7, no o_udf pulse.
REQ-036 The bench SHALL check: i_clr and i_load=1 (value 9) in the same cycle -> o_count=0, state IDLE; then i_enb high for 4 cycles -> o_count stays 0.
